// File: rtl/sga_pkg.sv
// Shared definitions for the Snake Game Arcade telemetry transmitter:
// parity modes, FSM encoding, default framing characters and hex conversion.
package sga_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [7:0] SEP_DEFAULT  = 8'h2C;
    localparam logic [7:0] TERM_DEFAULT = 8'h0A;

    // Externally visible state encoding, shown on the HEX display.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5,
        ST_GAP    = 3'd6
    } sga_state_e;

    // Frame-level sequencer; while transmitting, the bit phase comes from the char transmitter.
    typedef enum logic [1:0] {
        CTL_IDLE,
        CTL_LOAD,
        CTL_XMIT,
        CTL_GAP
    } ctl_state_e;

    typedef enum logic [1:0] {
        K_DIGIT,
        K_SEP,
        K_TERM
    } char_kind_e;

    function automatic logic [7:0] hexToAscii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/sga_telemetry_tx_if.sv
// Request/status bundle between the game logic and the telemetry transmitter.
interface sga_telemetry_tx_if
    import sga_pkg::*;
#(
    parameter int N_FIELDS = 6,
    parameter int FIELD_W  = 6
);

    logic                          start;
    logic [N_FIELDS*FIELD_W-1:0]   fields;
    logic [N_FIELDS-1:0]           field_en;
    logic                          saida_serial;
    logic                          busy;
    logic                          done;
    logic [7:0]                    dropped;
    sga_state_e                    db_state;

    modport master (
        output start, fields, field_en,
        input  saida_serial, busy, done, dropped, db_state
    );

    modport slave (
        input  start, fields, field_en,
        output saida_serial, busy, done, dropped, db_state
    );

endinterface

// File: rtl/sga_uart_tx_char.sv
// Serialises one 8-bit character: start bit, data LSB first, optional parity, stop bit.
// ready is high when idle or in the final cycle of the stop bit, so a new load chains characters back-to-back.
module sga_uart_tx_char
    import sga_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int PARITY  = PARITY_NONE
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] char_in,
    output logic       ready,
    output logic       saida_serial,
    output sga_state_e phase
);

    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic              PAR_INV   = (PARITY == PARITY_ODD);

    sga_state_e        state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              par_q;
    logic              serial_q;
    logic              bitEnd;

    assign bitEnd       = (baud_q == BAUD_LAST);
    assign ready        = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bitEnd);
    assign saida_serial = serial_q;
    assign phase        = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            case (state_q)
                ST_START: begin
                    if (!bitEnd) begin
                        baud_q <= baud_q + 1'b1;
                    end else begin
                        baud_q   <= '0;
                        bit_q    <= '0;
                        serial_q <= shift_q[0];
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!bitEnd) begin
                        baud_q <= baud_q + 1'b1;
                    end else begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            if (PARITY != PARITY_NONE) begin
                                serial_q <= par_q;
                                state_q  <= ST_PARITY;
                            end else begin
                                serial_q <= 1'b1;
                                state_q  <= ST_STOP;
                            end
                        end else begin
                            bit_q    <= bit_q + 3'd1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            serial_q <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (!bitEnd) begin
                        baud_q <= baud_q + 1'b1;
                    end else begin
                        baud_q   <= '0;
                        serial_q <= 1'b1;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (!bitEnd) begin
                        baud_q <= baud_q + 1'b1;
                    end else begin
                        baud_q <= '0;
                        if (load) begin
                            shift_q  <= char_in;
                            par_q    <= (^char_in) ^ PAR_INV;
                            serial_q <= 1'b0;
                            state_q  <= ST_START;
                        end else begin
                            serial_q <= 1'b1;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    baud_q <= '0;
                    if (load) begin
                        shift_q  <= char_in;
                        par_q    <= (^char_in) ^ PAR_INV;
                        serial_q <= 1'b0;
                        state_q  <= ST_START;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sga_telemetry_tx.sv
// Telemetry frame sequencer: snapshots the game fields on start, walks digits/separators/terminator
// through the character transmitter, enforces the inter-frame gap and counts rejected requests.
module sga_telemetry_tx
    import sga_pkg::*;
#(
    parameter int         N_FIELDS  = 6,
    parameter int         FIELD_W   = 6,
    parameter int         CLK_DIV   = 434,
    parameter int         PARITY    = PARITY_NONE,
    parameter int         GAP_CYC   = 5000,
    parameter logic [7:0] SEP_CHAR  = SEP_DEFAULT,
    parameter logic [7:0] TERM_CHAR = TERM_DEFAULT
)(
    input  logic             clock,
    input  logic             reset,
    sga_telemetry_tx_if.slave bus
);

    localparam int D     = (FIELD_W + 3) / 4;
    localparam int IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int DIG_W = (D > 1) ? $clog2(D) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    // Points at the character currently on the line.
    typedef struct packed {
        char_kind_e       kind;
        logic [IDX_W-1:0] fld;
        logic [DIG_W-1:0] dig;
    } ptr_t;

    ctl_state_e                  ctl_q;
    logic [N_FIELDS*FIELD_W-1:0] fields_q;
    logic [N_FIELDS-1:0]         en_q;
    ptr_t                        cur_q;
    logic [GAP_W-1:0]            gap_q;
    logic                        busy_q;
    logic                        done_q;
    logic [7:0]                  dropped_q;

    ptr_t                        firstPtr_d;
    ptr_t                        nextPtr_d;
    logic                        txLoad;
    logic [7:0]                  txChar_d;
    logic                        txReady;
    sga_state_e                  txPhase;
    sga_state_e                  dbState_d;

    function automatic logic [IDX_W:0] findEnabled(input logic [N_FIELDS-1:0] mask, input int from);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = N_FIELDS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    function automatic ptr_t firstOf(input logic [N_FIELDS-1:0] mask);
        ptr_t           p;
        logic [IDX_W:0] f;
        f      = findEnabled(mask, 0);
        p.fld  = f[IDX_W-1:0];
        p.dig  = '0;
        p.kind = f[IDX_W] ? K_DIGIT : K_TERM;
        return p;
    endfunction

    function automatic ptr_t nextOf(input ptr_t p, input logic [N_FIELDS-1:0] mask);
        ptr_t           n;
        logic [IDX_W:0] f;
        n = p;
        f = findEnabled(mask, int'(p.fld) + 1);
        case (p.kind)
            K_DIGIT: begin
                if (int'(p.dig) < D - 1) begin
                    n.dig = p.dig + 1'b1;
                end else if (f[IDX_W]) begin
                    n.kind = K_SEP;
                    n.fld  = f[IDX_W-1:0];
                    n.dig  = '0;
                end else begin
                    n.kind = K_TERM;
                    n.dig  = '0;
                end
            end
            K_SEP: begin
                n.kind = K_DIGIT;
                n.dig  = '0;
            end
            default: n.kind = K_TERM;
        endcase
        return n;
    endfunction

    // Digits go out MSB first from the field zero-extended to a whole number of nibbles.
    function automatic logic [7:0] charOf(input ptr_t p, input logic [N_FIELDS*FIELD_W-1:0] flds);
        logic [FIELD_W-1:0] f;
        logic [15:0]        ext;
        f = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (p.fld == IDX_W'(i)) begin
                f = flds[i*FIELD_W +: FIELD_W];
            end
        end
        ext = 16'(f) >> (4 * (D - 1 - int'(p.dig)));
        case (p.kind)
            K_DIGIT: return hexToAscii(ext[3:0]);
            K_SEP:   return SEP_CHAR;
            default: return TERM_CHAR;
        endcase
    endfunction

    // The next character is offered while the current stop bit is in its last cycle.
    always_comb begin
        firstPtr_d = firstOf(en_q);
        nextPtr_d  = nextOf(cur_q, en_q);
        txLoad     = 1'b0;
        txChar_d   = charOf(firstPtr_d, fields_q);
        if (ctl_q == CTL_LOAD) begin
            txLoad = 1'b1;
        end else if ((ctl_q == CTL_XMIT) && txReady && (cur_q.kind != K_TERM)) begin
            txLoad   = 1'b1;
            txChar_d = charOf(nextPtr_d, fields_q);
        end
    end

    always_comb begin
        case (ctl_q)
            CTL_LOAD: dbState_d = ST_LOAD;
            CTL_XMIT: dbState_d = txPhase;
            CTL_GAP:  dbState_d = ST_GAP;
            default:  dbState_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctl_q     <= CTL_IDLE;
            fields_q  <= '0;
            en_q      <= '0;
            cur_q     <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.start && busy_q && (dropped_q != 8'hFF)) begin
                dropped_q <= dropped_q + 8'd1;
            end
            case (ctl_q)
                CTL_LOAD: begin
                    cur_q <= firstPtr_d;
                    ctl_q <= CTL_XMIT;
                end
                CTL_XMIT: begin
                    if (txReady) begin
                        if (cur_q.kind == K_TERM) begin
                            if (GAP_CYC == 0) begin
                                ctl_q  <= CTL_IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                ctl_q <= CTL_GAP;
                                gap_q <= '0;
                            end
                        end else begin
                            cur_q <= nextPtr_d;
                        end
                    end
                end
                CTL_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        ctl_q  <= CTL_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    if (bus.start) begin
                        fields_q <= bus.fields;
                        en_q     <= bus.field_en;
                        busy_q   <= 1'b1;
                        ctl_q    <= CTL_LOAD;
                    end
                end
            endcase
        end
    end

    sga_uart_tx_char #(
        .CLK_DIV (CLK_DIV),
        .PARITY  (PARITY)
    ) u_char (
        .clock        (clock),
        .reset        (reset),
        .load         (txLoad),
        .char_in      (txChar_d),
        .ready        (txReady),
        .saida_serial (bus.saida_serial),
        .phase        (txPhase)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.dropped  = dropped_q;
    assign bus.db_state = dbState_d;

endmodule

// File: tb/tb_sga_telemetry_tx.sv
// Scoreboard bench: stimulus pushes hand-computed frame bytes, per-line UART monitors decode and compare.
module tb_sga_telemetry_tx;
    import sga_pkg::*;

    localparam int CLK_DIV = 4;

    logic clock;
    logic resetN;
    int   cyc;
    int   checks;
    int   failures;
    bit   monEnable [2];

    logic [7:0] expQ0 [$];
    logic [8:0] expQ1 [$];

    sga_telemetry_tx_if #(.N_FIELDS(2), .FIELD_W(6)) if0 ();
    sga_telemetry_tx_if #(.N_FIELDS(2), .FIELD_W(6)) if1 ();

    sga_telemetry_tx #(
        .N_FIELDS(2), .FIELD_W(6), .CLK_DIV(CLK_DIV), .PARITY(PARITY_NONE), .GAP_CYC(8),
        .SEP_CHAR(8'h2C), .TERM_CHAR(8'h0A)
    ) dut0 (
        .clock (clock),
        .reset (resetN),
        .bus   (if0)
    );

    sga_telemetry_tx #(
        .N_FIELDS(2), .FIELD_W(6), .CLK_DIV(CLK_DIV), .PARITY(PARITY_ODD), .GAP_CYC(8),
        .SEP_CHAR(8'h2C), .TERM_CHAR(8'h0A)
    ) dut1 (
        .clock (clock),
        .reset (resetN),
        .bus   (if1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic logic lineOf(input int s);
        return (s == 0) ? if0.saida_serial : if1.saida_serial;
    endfunction

    function automatic logic doneOf(input int s);
        return (s == 0) ? if0.done : if1.done;
    endfunction

    // Call at a negedge; start is high for exactly one sampling edge. tS is the request cycle.
    task automatic applyStimulus(input int s, input logic [11:0] f, input logic [1:0] e, output int tS);
        if (s == 0) begin
            if0.fields = f; if0.field_en = e; if0.start = 1'b1;
        end else begin
            if1.fields = f; if1.field_en = e; if1.start = 1'b1;
        end
        tS = cyc;
        @(negedge clock);
        if (s == 0) if0.start = 1'b0;
        else        if1.start = 1'b0;
    endtask

    task automatic waitDone(input int s, input int budget, output int doneCyc);
        bit seen;
        seen    = 1'b0;
        doneCyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (doneOf(s)) begin
                seen    = 1'b1;
                doneCyc = cyc;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL doneTimeout dut%0d: got no done, want done within %0d cycles", s, budget);
        end
    endtask

    task automatic pushFullFrame();
        expQ0.push_back(8'h30); expQ0.push_back(8'h35); expQ0.push_back(8'h2C);
        expQ0.push_back(8'h32); expQ0.push_back(8'h41); expQ0.push_back(8'h0A);
    endtask

    // Samples the middle of each bit; the start-bit low is first seen half a cycle into the bit.
    task automatic monitorLine(input int s);
        logic [7:0] data;
        logic       par;
        logic       stopBit;
        forever begin
            @(negedge clock);
            if (resetN && (lineOf(s) == 1'b0)) begin
                @(negedge clock);
                for (int b = 0; b < 8; b++) begin
                    repeat (CLK_DIV) @(negedge clock);
                    data[b] = lineOf(s);
                end
                par = 1'b0;
                if (s == 1) begin
                    repeat (CLK_DIV) @(negedge clock);
                    par = lineOf(s);
                end
                repeat (CLK_DIV) @(negedge clock);
                stopBit = lineOf(s);
                if (monEnable[s]) begin
                    checkOutput($sformatf("stopBit dut%0d", s), {31'd0, stopBit}, 32'd1);
                    if (s == 0) begin
                        if (expQ0.size() == 0) checkOutput("unexpectedByte dut0", {24'd0, data}, 32'hFFFF_FFFF);
                        else                   checkOutput("byte dut0", {24'd0, data}, {24'd0, expQ0.pop_front()});
                    end else begin
                        if (expQ1.size() == 0) checkOutput("unexpectedByte dut1", {23'd0, par, data}, 32'hFFFF_FFFF);
                        else                   checkOutput("parity+byte dut1", {23'd0, par, data}, {23'd0, expQ1.pop_front()});
                    end
                end
            end
        end
    endtask

    initial begin
        int tS;
        int dc;
        int doneCount;
        cyc = 0; checks = 0; failures = 0;
        monEnable[0] = 1'b1; monEnable[1] = 1'b1;
        if0.start = 1'b0; if0.fields = '0; if0.field_en = '0;
        if1.start = 1'b0; if1.fields = '0; if1.field_en = '0;
        resetN = 1'b0;

        fork
            monitorLine(0);
            monitorLine(1);
        join_none

        repeat (3) @(negedge clock);
        checkOutput("reset serial", {31'd0, if0.saida_serial}, 32'd1);
        checkOutput("reset busy", {31'd0, if0.busy}, 32'd0);
        checkOutput("reset done", {31'd0, if0.done}, 32'd0);
        checkOutput("reset dropped", {24'd0, if0.dropped}, 32'd0);
        checkOutput("reset db_state", {29'd0, if0.db_state}, 32'd0);
        checkOutput("reset serial dut1", {31'd0, if1.saida_serial}, 32'd1);
        resetN = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] full frame, both fields");
        pushFullFrame();
        applyStimulus(0, {6'h2A, 6'h05}, 2'b11, tS);
        checkOutput("busy at t+1", {31'd0, if0.busy}, 32'd1);
        checkOutput("db LOAD at t+1", {29'd0, if0.db_state}, 32'd1);
        checkOutput("serial idle at t+1", {31'd0, if0.saida_serial}, 32'd1);
        @(negedge clock);
        checkOutput("db START at t+2", {29'd0, if0.db_state}, 32'd2);
        checkOutput("start bit at t+2", {31'd0, if0.saida_serial}, 32'd0);
        waitDone(0, 400, dc);
        checkOutput("full frame cycles", dc - tS, 32'd250);
        checkOutput("busy low on done", {31'd0, if0.busy}, 32'd0);
        @(negedge clock);
        checkOutput("done single pulse", {31'd0, if0.done}, 32'd0);
        checkOutput("bytes left full", expQ0.size(), 32'd0);

        $display("[TB] masked frame 2'b10");
        expQ0.push_back(8'h32); expQ0.push_back(8'h41); expQ0.push_back(8'h0A);
        applyStimulus(0, {6'h2A, 6'h05}, 2'b10, tS);
        waitDone(0, 400, dc);
        checkOutput("masked frame cycles", dc - tS, 32'd130);
        @(negedge clock);

        $display("[TB] empty mask");
        expQ0.push_back(8'h0A);
        applyStimulus(0, {6'h2A, 6'h05}, 2'b00, tS);
        waitDone(0, 400, dc);
        checkOutput("empty frame cycles", dc - tS, 32'd50);
        checkOutput("bytes left masked", expQ0.size(), 32'd0);
        @(negedge clock);

        $display("[TB] drops and snapshot");
        pushFullFrame();
        applyStimulus(0, {6'h2A, 6'h05}, 2'b11, tS);
        repeat (10) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            if0.start = 1'b1;
            @(negedge clock);
            if0.start = 1'b0;
            @(negedge clock);
        end
        if0.fields = {6'h3F, 6'h3F};
        if0.field_en = 2'b01;
        waitDone(0, 400, dc);
        checkOutput("snapshot frame cycles", dc - tS, 32'd250);
        checkOutput("dropped after 3", {24'd0, if0.dropped}, 32'd3);

        $display("[TB] start on done cycle");
        pushFullFrame();
        applyStimulus(0, {6'h2A, 6'h05}, 2'b11, tS);
        checkOutput("accepted on done busy", {31'd0, if0.busy}, 32'd1);
        checkOutput("dropped unchanged", {24'd0, if0.dropped}, 32'd3);
        waitDone(0, 400, dc);
        checkOutput("back-to-back frame cycles", dc - tS, 32'd250);
        @(negedge clock);

        $display("[TB] odd parity");
        expQ1.push_back(9'h032); expQ1.push_back(9'h141); expQ1.push_back(9'h10A);
        applyStimulus(1, {6'h2A, 6'h05}, 2'b10, tS);
        repeat (38) @(negedge clock);
        checkOutput("db PARITY dut1", {29'd0, if1.db_state}, 32'd4);
        checkOutput("parity bit of 0x32", {31'd0, if1.saida_serial}, 32'd0);
        waitDone(1, 400, dc);
        checkOutput("parity frame cycles", dc - tS, 32'd142);
        checkOutput("bytes left dut1", expQ1.size(), 32'd0);
        @(negedge clock);

        $display("[TB] reset mid-character");
        monEnable[0] = 1'b0;
        applyStimulus(0, {6'h2A, 6'h05}, 2'b11, tS);
        repeat (7) @(negedge clock);
        checkOutput("db DATA before reset", {29'd0, if0.db_state}, 32'd3);
        resetN = 1'b0;
        #1;
        checkOutput("abort serial", {31'd0, if0.saida_serial}, 32'd1);
        checkOutput("abort busy", {31'd0, if0.busy}, 32'd0);
        checkOutput("abort dropped", {24'd0, if0.dropped}, 32'd0);
        checkOutput("abort db_state", {29'd0, if0.db_state}, 32'd0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        repeat (50) @(negedge clock);
        monEnable[0] = 1'b1;
        pushFullFrame();
        applyStimulus(0, {6'h2A, 6'h05}, 2'b11, tS);
        waitDone(0, 400, dc);
        checkOutput("post-reset frame cycles", dc - tS, 32'd250);
        checkOutput("bytes left post-reset", expQ0.size(), 32'd0);
        @(negedge clock);

        $display("[TB] drop counter saturation");
        pushFullFrame();
        pushFullFrame();
        if0.fields = {6'h2A, 6'h05};
        if0.field_en = 2'b11;
        if0.start = 1'b1;
        tS = cyc;
        doneCount = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (if0.done) doneCount++;
        end
        if0.start = 1'b0;
        checkOutput("done pulses while held", doneCount, 32'd1);
        waitDone(0, 400, dc);
        checkOutput("second held frame cycles", dc - tS, 32'd500);
        checkOutput("dropped saturated", {24'd0, if0.dropped}, 32'd255);

        repeat (5) @(negedge clock);
        checkOutput("bytes left dut0", expQ0.size(), 32'd0);
        checkOutput("bytes left dut1 end", expQ1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
